// File: rtl/transmit_stream_pkg.sv
// Shared defaults and FSM encoding for the transmit stream block.
// Imported by the stream controller and its instruction buffer.
package transmit_stream_pkg;
  localparam int IWIDTH_DEF = 32;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/transmit_stream_instr_buf.sv
// Simple dual-port instruction RAM: one write port, one registered read.
// A same-address write and read on one edge returns the old word.
module instr_buf
  import transmit_stream_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [IWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [IWIDTH-1:0] rd_data
);
  logic [IWIDTH-1:0] mem_q [DEPTH];
  logic [IWIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/transmit_stream.sv
// Streams a window of the instruction buffer downstream over valid/ready,
// optionally repeating the window until aborted.
module transmit_stream
  import transmit_stream_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              t_i_wr_en,
  input  logic [AW-1:0]     t_i_wr_addr,
  input  logic [IWIDTH-1:0] t_i_wr_data,
  input  logic              t_i_syn,
  input  logic [AW-1:0]     t_i_base,
  input  logic [AW:0]       t_i_len,
  input  logic              t_i_loop,
  input  logic              t_i_abort,
  input  logic              t_i_ready,
  output logic [IWIDTH-1:0] t_o_instr,
  output logic              t_o_valid,
  output logic              t_o_last,
  output logic              t_o_ack,
  output logic              t_o_busy
);
  state_e          state_q, state_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW:0]     len_q, len_d;
  logic            loop_q, loop_d;
  logic            rd_en;
  logic            xfer;
  logic [IWIDTH-1:0] rd_data;

  assign xfer = (state_q == S_SEND) && t_i_ready;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    loop_d   = loop_q;
    rd_en    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (t_i_syn) begin
          base_d = t_i_base;
          len_d  = t_i_len;
          loop_d = t_i_loop;
          if (t_i_len != '0) begin
            rd_ptr_d = t_i_base;
            cnt_d    = t_i_len;
            state_d  = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = t_i_abort ? S_DONE : S_SEND;
      end
      S_SEND: begin
        // The read address is the post-transfer pointer, so the next
        // word lands in the output register on the transfer edge.
        if (xfer) begin
          if (cnt_q == (AW+1)'(1)) begin
            if (loop_q) begin
              rd_ptr_d = base_q;
              cnt_d    = len_q;
              rd_en    = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            cnt_d    = cnt_q - (AW+1)'(1);
            rd_en    = 1'b1;
          end
        end
        if (t_i_abort) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge t_clk) begin
    if (t_rst) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
      loop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      loop_q   <= loop_d;
    end
  end

  instr_buf #(
    .IWIDTH(IWIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk    (t_clk),
    .rst    (t_rst),
    .wr_en  (t_i_wr_en),
    .wr_addr(t_i_wr_addr),
    .wr_data(t_i_wr_data),
    .rd_en  (rd_en),
    .rd_addr(rd_ptr_d),
    .rd_data(rd_data)
  );

  assign t_o_valid = (state_q == S_SEND);
  assign t_o_last  = t_o_valid && (cnt_q == (AW+1)'(1));
  assign t_o_ack   = (state_q == S_DONE);
  assign t_o_busy  = (state_q != S_IDLE);
  assign t_o_instr = t_o_valid ? rd_data : '0;
endmodule
